synapse_bank: RTL and testbench

Parametrised bank of N_SYN conductance synapses sharing one dendrite compartment, the successor to the single on/off synapse. Each channel matches its own address on the spike bus, raises or lowers a saturating conductance by its own weight, and feeds one time-multiplexed current calculation. The bank sits between the spike input bus and one `synapse_dendrite_if`. It replaces N chained single synapses and uses one multiplier instead of N.

---
 rtl/synapse_bank_if.sv | 29 ++
 rtl/synapse_bank.sv | 180 ++++++++++++++++++
 tb/tb_synapse_bank.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/synapse_bank_if.sv
// rtl/synapse_bank_if.sv - fixed-point type package and bus interfaces used by synapse_bank
package fp;
    typedef logic signed [15:0] fpType;
endpackage

interface spike_in_if;
    logic       valid;
    logic [7:0] address;
    logic       on_off;

    modport master (output valid, output address, output on_off);
    modport slave  (input valid, input address, input on_off);
endinterface

interface synapse_dendrite_if;
    fp::fpType vmem;
    fp::fpType output_current;

    modport synapse  (input vmem, output output_current);
    modport dendrite (output vmem, input output_current);
endinterface

interface config_if;
    logic        data_clk;
    logic [15:0] data_in;

    modport master (output data_clk, output data_in);
    modport slave  (input data_clk, input data_in);
endinterface

// File: rtl/synapse_bank.sv
// rtl/synapse_bank.sv - N_SYN conductance synapses sharing one multiplier into a dendrite
// Optional exponential conductance decay: define SYNAPSE_BANK_DECAY_EN.
module synapse_bank #(
    parameter int          N_SYN       = 4,
    parameter logic [15:0] GSYN_MAX    = 16'h7fff,
    parameter int          SHIFT       = 9,
    parameter int          DECAY_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spike_in_if.slave            input_spike,
    synapse_dendrite_if.synapse  dendrite,
    config_if.slave              cfg_in,
    config_if.master             cfg_out,
    input  logic signed [15:0]   E_rev
);

    localparam int IDX_W     = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam int ACC_W     = 33 + $clog2(N_SYN);
    localparam int CHAIN_LEN = 2 * N_SYN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [IDX_W-1:0]          idx_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_sh;
    logic signed [16:0]        diff_q;
    logic signed [16:0]        gsyn_sel;
    logic signed [33:0]        prod;
    logic [15:0]               out_q;
    logic [15:0]               out_sat;
    logic                      out_fits;

    // chain[2k] = weight[k], chain[2k+1] = cfg[k]
    logic [15:0]               chain [CHAIN_LEN];
    logic                      sync1;
    logic                      sync2;
    logic                      sync3;
    logic                      cfg_shift;

    logic [15:0]               gsyn     [N_SYN];
    logic [15:0]               gsyn_nxt [N_SYN];
    logic [N_SYN-1:0]          hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= cfg_in.data_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign cfg_shift = sync2 & ~sync3;

    // Configuration survives reset so a soft reset keeps the loaded network.
    always_ff @(posedge clk) begin
        if (cfg_shift) begin
            chain[0] <= cfg_in.data_in;
            for (int i = 1; i < CHAIN_LEN; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign cfg_out.data_clk = cfg_in.data_clk;
    assign cfg_out.data_in  = chain[CHAIN_LEN-1];

    function automatic logic [15:0] spike_step(input logic [15:0] g, input logic [15:0] w,
                                               input logic up);
        logic [16:0] s;
        if (up) begin
            s = {1'b0, g} + {1'b0, w};
            spike_step = (s > {1'b0, GSYN_MAX}) ? GSYN_MAX : s[15:0];
        end else begin
            s = {1'b0, g} - {1'b0, w};
            spike_step = s[16] ? 16'd0 : s[15:0];
        end
    endfunction

    always_comb begin
        for (int k = 0; k < N_SYN; k++) begin
            hit[k] = input_spike.valid && chain[2*k+1][8] &&
                     (input_spike.address == chain[2*k+1][7:0]);
            gsyn_nxt[k] = gsyn[k];
            if (hit[k]) begin
                gsyn_nxt[k] = spike_step(gsyn[k], chain[2*k], input_spike.on_off);
            end
`ifdef SYNAPSE_BANK_DECAY_EN
            else if (state_q == ST_OUT) begin
                gsyn_nxt[k] = gsyn[k] - (gsyn[k] >> DECAY_SHIFT);
            end
`endif
        end
    end

`ifndef SYNAPSE_BANK_DECAY_EN
    // Without decay DECAY_SHIFT has no effect beyond this range check.
    if (DECAY_SHIFT < 0 || DECAY_SHIFT > 15) begin : g_decay_shift_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_SYN; k++) begin
                gsyn[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < N_SYN; k++) begin
                gsyn[k] <= gsyn_nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_ACC;
            ST_ACC:  if (idx_q == IDX_W'(N_SYN - 1)) state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single shared multiplier walks the channels; gsyn is read live.
    assign gsyn_sel = $signed({1'b0, gsyn[idx_q]});
    assign prod     = 34'(gsyn_sel) * 34'(diff_q);

    assign acc_sh   = acc_q >>> SHIFT;
    assign out_fits = (acc_sh[ACC_W-1:15] == '0) || (acc_sh[ACC_W-1:15] == '1);
    assign out_sat  = out_fits ? acc_sh[15:0] : (acc_sh[ACC_W-1] ? 16'h8000 : 16'h7fff);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            acc_q  <= '0;
            diff_q <= '0;
            out_q  <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_q  <= '0;
                    idx_q  <= '0;
                    diff_q <= $signed({E_rev[15], E_rev}) -
                              $signed({dendrite.vmem[15], dendrite.vmem});
                end
                ST_ACC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    idx_q <= idx_q + IDX_W'(1);
                end
                ST_OUT: begin
                    out_q <= out_sat;
                end
                default: begin
                    idx_q <= '0;
                end
            endcase
        end
    end

    assign dendrite.output_current = out_q;

endmodule

// File: tb/tb_synapse_bank.sv
// tb/tb_synapse_bank.sv - directed self-checking bench for synapse_bank (N_SYN=4)
module tb_synapse_bank;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] e_rev;
    int                 checks = 0;
    int                 errors = 0;
    logic [15:0]        tbl [8];

    spike_in_if         spk ();
    synapse_dendrite_if dend ();
    config_if           cin ();
    config_if           cout ();

    synapse_bank dut (
        .clk         (clk),
        .reset       (reset),
        .input_spike (spk),
        .dendrite    (dend),
        .cfg_in      (cin),
        .cfg_out     (cout),
        .E_rev       (e_rev)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic shift_word(input logic [15:0] w);
        cin.data_in  = w;
        cin.data_clk = 1'b1;
        repeat (4) tick();
        cin.data_clk = 1'b0;
        repeat (2) tick();
    endtask

    task automatic load_tbl();
        for (int i = 0; i < 8; i++) shift_word(tbl[i]);
    endtask

    task automatic spike(input logic [7:0] addr, input logic up);
        spk.valid   = 1'b1;
        spk.address = addr;
        spk.on_off  = up;
        tick();
        spk.valid   = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int n;
        n = 0;
        while (dut.state_q !== st && n < 20) begin
            tick();
            n++;
        end
        check(tag, {30'd0, dut.state_q}, {30'd0, st});
    endtask

    initial begin
        reset        = 1'b1;
        e_rev        = 16'sd0;
        dend.vmem    = 16'sd0;
        spk.valid    = 1'b0;
        spk.address  = 8'h00;
        spk.on_off   = 1'b0;
        cin.data_clk = 1'b0;
        cin.data_in  = 16'h0000;
        repeat (3) tick();
        check("reset_out", $signed(dend.output_current), 0);
        check("reset_gsyn0", {16'd0, dut.gsyn[0]}, 0);
        reset = 1'b0;
        tick();

        cin.data_clk = 1'b1;
        #1;
        check("cfg_clk_pass", {31'd0, cout.data_clk}, 1);
        cin.data_clk = 1'b0;
        repeat (3) tick();

        // chain loads cfg[3] first; it ends up nearest cfg_out
        tbl = '{16'h0113, 16'd400, 16'h0112, 16'd300, 16'h0111, 16'd200, 16'h0110, 16'd100};
        load_tbl();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("readback_%0d", i), {16'd0, cout.data_in}, {16'd0, tbl[i]});
            shift_word(tbl[i]);
        end

`ifndef SYNAPSE_BANK_DECAY_EN
        repeat (3) spike(8'h11, 1'b1);
        check("gsyn1_up3", {16'd0, dut.gsyn[1]}, 600);
        check("gsyn0_untouched", {16'd0, dut.gsyn[0]}, 0);
        spike(8'h55, 1'b1);
        check("nomatch_addr", {16'd0, dut.gsyn[1]}, 600);
        repeat (4) spike(8'h11, 1'b0);
        check("gsyn1_floor", {16'd0, dut.gsyn[1]}, 0);

        tbl = '{16'h0120, 16'h4000, 16'h0120, 16'h4000, 16'h0120, 16'h4000, 16'h0110, 16'd512};
        load_tbl();
        spike(8'h10, 1'b1);
        check("gsyn0_512", {16'd0, dut.gsyn[0]}, 512);
        e_rev     = 16'sd1000;
        dend.vmem = -16'sd24;
        repeat (12) tick();
        check("current_1024", $signed(dend.output_current), 1024);

        repeat (3) spike(8'h20, 1'b1);
        check("gsyn2_ceiling", {16'd0, dut.gsyn[2]}, 32767);
        check("gsyn3_shared", {16'd0, dut.gsyn[3]}, 32767);
        e_rev     = 16'sd32767;
        dend.vmem = -16'sd32768;
        repeat (12) tick();
        check("current_sat_pos", $signed(dend.output_current), 32767);
        e_rev     = -16'sd32768;
        dend.vmem = 16'sd32767;
        repeat (12) tick();
        check("current_sat_neg", $signed(dend.output_current), -32768);
`else
        tbl = '{16'h0000, 16'd0, 16'h0000, 16'd0, 16'h0000, 16'd0, 16'h0110, 16'd1600};
        load_tbl();
        wait_state(2'd2, "align_out");
        tick();
        spike(8'h10, 1'b1);
        check("decay_start", {16'd0, dut.gsyn[0]}, 1600);
        repeat (5) tick();
        check("decay_frame1", {16'd0, dut.gsyn[0]}, 1500);
        repeat (6) tick();
        check("decay_frame2", {16'd0, dut.gsyn[0]}, 1407);
        e_rev     = 16'sd1000;
        dend.vmem = 16'sd0;
        repeat (12) tick();
`endif

        wait_state(2'd1, "reach_acc");
        reset       = 1'b1;
        spk.valid   = 1'b1;
        spk.address = 8'h10;
        spk.on_off  = 1'b1;
        tick();
        check("midframe_reset_out", $signed(dend.output_current), 0);
        check("midframe_reset_gsyn0", {16'd0, dut.gsyn[0]}, 0);
        check("midframe_reset_state", {30'd0, dut.state_q}, 0);
        spk.valid = 1'b0;
        reset     = 1'b0;
        tick();
        check("spike_in_reset_dropped", {16'd0, dut.gsyn[0]}, 0);
        repeat (12) tick();
        check("idle_current_zero", $signed(dend.output_current), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
